// File: rtl/lms_adapt_ctrl.sv
// LMS coefficient-adaptation sequencer: training/tracking phases, windowed |e| retrain monitor,
// shadow coefficient bank with commit pulse. Define LMS_ADAPT_CTRL_ERRMON_EN for o_err_sum/o_err_alarm.
module lms_adapt_ctrl #(
    parameter int NBe       = 9,
    parameter int Nw        = 9,
    parameter int NBw       = 7,
    parameter int NBFw      = 5,
    parameter int TRAIN_LEN = 600,
    parameter int WIN_LOG2  = 6,
    parameter int ERR_TH    = 2048
) (
    input  logic                  clkA,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_freeze,
    input  logic                  i_sym_valid,
    input  logic signed [NBe-1:0] i_e,
    input  logic                  cfg_wr_valid,
    output logic                  cfg_wr_ready,
    input  logic [3:0]            cfg_wr_idx,
    input  logic signed [NBw-1:0] cfg_wr_data,
    input  logic                  cfg_commit,
    output logic                  o_enable,
    output logic                  o_debug_load,
    output logic [Nw*NBw-1:0]     o_coeffs,
`ifdef LMS_ADAPT_CTRL_ERRMON_EN
    output logic [NBe+WIN_LOG2-1:0] o_err_sum,
    output logic                    o_err_alarm,
`endif
    output logic [2:0]            o_state,
    output logic [7:0]            o_retrain_cnt
);

    localparam int AW = NBe + WIN_LOG2;
    localparam int CW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COMMIT = 3'd1,
        TRAIN  = 3'd2,
        TRACK  = 3'd3,
        FREEZE = 3'd4
    } state_t;

    state_t                  state, state_nx;
    logic                    ret_frz, ret_frz_nx;
    logic [CW-1:0]           sym_cnt, sym_cnt_nx;
    logic [WIN_LOG2-1:0]     win_cnt, win_cnt_nx;
    logic [AW-1:0]           acc, acc_nx;
    logic                    retrain, win_done;
    logic [NBe-1:0]          e_raw, e_mag;
    logic [AW-1:0]           win_sum;
    logic [Nw-1:0][NBw-1:0]  shadow;

    // Magnitude kept unsigned so the most negative error maps to 2^(NBe-1) without wrapping
    assign e_raw   = i_e;
    assign e_mag   = e_raw[NBe-1] ? (~e_raw + 1'b1) : e_raw;
    assign win_sum = acc + AW'(e_mag);

    always_comb begin
        state_nx   = state;
        ret_frz_nx = ret_frz;
        sym_cnt_nx = sym_cnt;
        win_cnt_nx = win_cnt;
        acc_nx     = acc;
        retrain    = 1'b0;
        win_done   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_commit) begin
                    state_nx   = COMMIT;
                    ret_frz_nx = 1'b0;
                end else if (i_start) begin
                    state_nx   = TRAIN;
                    sym_cnt_nx = '0;
                end
            end
            COMMIT: state_nx = ret_frz ? FREEZE : IDLE;
            TRAIN: begin
                if (i_freeze) begin
                    state_nx = FREEZE;
                end else if (i_sym_valid) begin
                    if (sym_cnt == CW'(TRAIN_LEN - 1)) begin
                        state_nx   = TRACK;
                        sym_cnt_nx = '0;
                        win_cnt_nx = '0;
                        acc_nx     = '0;
                    end else begin
                        sym_cnt_nx = sym_cnt + 1'b1;
                    end
                end
            end
            TRACK: begin
                if (i_freeze) begin
                    state_nx = FREEZE;
                end else if (i_sym_valid) begin
                    win_cnt_nx = win_cnt + 1'b1;
                    if (&win_cnt) begin
                        win_done = 1'b1;
                        acc_nx   = '0;
                        if (win_sum > AW'(ERR_TH)) begin
                            retrain    = 1'b1;
                            state_nx   = TRAIN;
                            sym_cnt_nx = '0;
                            win_cnt_nx = '0;
                        end
                    end else begin
                        acc_nx = win_sum;
                    end
                end
            end
            FREEZE: begin
                if (cfg_commit) begin
                    state_nx   = COMMIT;
                    ret_frz_nx = 1'b1;
                end else if (!i_freeze) begin
                    // Resume always lands in TRACK with a fresh window, even from mid-training
                    state_nx   = TRACK;
                    win_cnt_nx = '0;
                    acc_nx     = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ret_frz       <= 1'b0;
            sym_cnt       <= '0;
            win_cnt       <= '0;
            acc           <= '0;
            o_enable      <= 1'b0;
            o_retrain_cnt <= '0;
        end else begin
            state    <= state_nx;
            ret_frz  <= ret_frz_nx;
            sym_cnt  <= sym_cnt_nx;
            win_cnt  <= win_cnt_nx;
            acc      <= acc_nx;
            o_enable <= i_sym_valid & ((state == TRAIN) | (state == TRACK)) & ~i_freeze;
            if (retrain && (o_retrain_cnt != 8'hFF))
                o_retrain_cnt <= o_retrain_cnt + 1'b1;
        end
    end

    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < Nw; k++)
                shadow[k] <= (k == Nw / 2) ? NBw'(1 << NBFw) : '0;
        end else if (cfg_wr_valid && cfg_wr_ready) begin
            for (int k = 0; k < Nw; k++)
                if (cfg_wr_idx == 4'(k)) shadow[k] <= cfg_wr_data;
        end
    end

`ifdef LMS_ADAPT_CTRL_ERRMON_EN
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            o_err_sum   <= '0;
            o_err_alarm <= 1'b0;
        end else begin
            o_err_alarm <= retrain;
            if (win_done) o_err_sum <= win_sum;
        end
    end
`endif

    assign cfg_wr_ready = (state == IDLE) || (state == FREEZE);
    assign o_debug_load = (state == COMMIT);
    assign o_coeffs     = shadow;
    assign o_state      = state;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Directed bench for lms_adapt_ctrl: reset, config/commit, training, retrain, freeze, boundaries.
module tb_lms_adapt_ctrl;
    localparam int NBe = 9;
    localparam int Nw  = 9;
    localparam int NBw = 7;
    localparam int WL  = 6;

    logic                  clkA = 1'b0;
    logic                  reset = 1'b1;
    logic                  i_start = 1'b0, i_freeze = 1'b0, i_sym_valid = 1'b0;
    logic signed [NBe-1:0] i_e = '0;
    logic                  cfg_wr_valid = 1'b0, cfg_commit = 1'b0;
    logic                  cfg_wr_ready;
    logic [3:0]            cfg_wr_idx = '0;
    logic signed [NBw-1:0] cfg_wr_data = '0;
    logic                  o_enable, o_debug_load;
    logic [Nw*NBw-1:0]     o_coeffs;
    logic [2:0]            o_state;
    logic [7:0]            o_retrain_cnt;
`ifdef LMS_ADAPT_CTRL_ERRMON_EN
    logic [NBe+WL-1:0]     o_err_sum;
    logic                  o_err_alarm;
`endif

    int checks = 0;
    int errors = 0;
    logic [Nw*NBw-1:0] exp_coeffs;
    logic [Nw*NBw-1:0] def_coeffs;

    always #5 clkA = ~clkA;

    lms_adapt_ctrl dut (
        .clkA(clkA), .reset(reset), .i_start(i_start), .i_freeze(i_freeze),
        .i_sym_valid(i_sym_valid), .i_e(i_e), .cfg_wr_valid(cfg_wr_valid),
        .cfg_wr_ready(cfg_wr_ready), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .o_enable(o_enable), .o_debug_load(o_debug_load),
        .o_coeffs(o_coeffs),
`ifdef LMS_ADAPT_CTRL_ERRMON_EN
        .o_err_sum(o_err_sum), .o_err_alarm(o_err_alarm),
`endif
        .o_state(o_state), .o_retrain_cnt(o_retrain_cnt)
    );

    task automatic strobe(input logic signed [NBe-1:0] e, output logic en_pre, output logic en_post);
        @(negedge clkA); en_pre = o_enable; i_sym_valid = 1'b1; i_e = e;
        @(negedge clkA); i_sym_valid = 1'b0; en_post = o_enable;
    endtask

    task automatic burst(input int n, input logic signed [NBe-1:0] e);
        for (int i = 0; i < n; i++) begin
            @(negedge clkA); i_sym_valid = 1'b1; i_e = e;
        end
        @(negedge clkA); i_sym_valid = 1'b0;
    endtask

    // TRAIN -> FREEZE -> TRACK shortcut
    task automatic to_track;
        @(negedge clkA); i_freeze = 1'b1;
        @(negedge clkA); i_freeze = 1'b0;
        @(negedge clkA);
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic signed [NBw-1:0] d, input logic exp_rdy);
        @(negedge clkA); cfg_wr_valid = 1'b1; cfg_wr_idx = idx; cfg_wr_data = d;
        #1;
        checks++;
        if (cfg_wr_ready !== exp_rdy) begin
            errors++; $display("FAIL cfg_wr_ready idx=%0d: got %b expected %b", idx, cfg_wr_ready, exp_rdy);
        end
        @(negedge clkA); cfg_wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic pre, post;
        #3 reset = 1'b0;
        #10;
        checks += 5;
        if (o_coeffs !== def_coeffs) begin errors++; $display("FAIL reset_coeffs: got %h expected %h", o_coeffs, def_coeffs); end
        if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        if (o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", o_enable); end
        if (o_debug_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", o_debug_load); end
        if (o_retrain_cnt !== 8'd0) begin errors++; $display("FAIL reset_retrain_cnt: got %0d expected 0", o_retrain_cnt); end
        @(negedge clkA); reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            strobe(9'sd5, pre, post);
            checks++;
            if (o_state !== 3'd0 || post !== 1'b0) begin
                errors++; $display("FAIL idle_no_start sym %0d: state %0d en %b expected 0/0", i, o_state, post);
            end
        end
    endtask

    task automatic test_cfg_commit;
        cfg_write(4'd3, -7'sd5, 1'b1);
        cfg_write(4'd12, 7'sd7, 1'b1);
        exp_coeffs[3*NBw +: NBw] = 7'h7B;
        checks++;
        if (o_coeffs !== exp_coeffs) begin errors++; $display("FAIL cfg_write_coeffs: got %h expected %h", o_coeffs, exp_coeffs); end
        // commit and start together: commit wins, start dropped
        @(negedge clkA); cfg_commit = 1'b1; i_start = 1'b1;
        @(negedge clkA); cfg_commit = 1'b0; i_start = 1'b0;
        checks += 2;
        if (o_state !== 3'd1) begin errors++; $display("FAIL commit_state: got %0d expected 1", o_state); end
        if (o_debug_load !== 1'b1) begin errors++; $display("FAIL commit_load_hi: got %b expected 1", o_debug_load); end
        @(negedge clkA);
        checks += 2;
        if (o_state !== 3'd0) begin errors++; $display("FAIL commit_return_idle: got %0d expected 0", o_state); end
        if (o_debug_load !== 1'b0) begin errors++; $display("FAIL commit_load_lo: got %b expected 0", o_debug_load); end
    endtask

    task automatic test_train;
        logic pre, post;
        int en_cnt, pre_bad;
        en_cnt = 0; pre_bad = 0;
        @(negedge clkA); i_start = 1'b1;
        @(negedge clkA); i_start = 1'b0;
        checks++;
        if (o_state !== 3'd2) begin errors++; $display("FAIL train_entry: got %0d expected 2", o_state); end
        cfg_write(4'd0, 7'sd17, 1'b0);
        checks++;
        if (o_coeffs !== exp_coeffs) begin errors++; $display("FAIL train_write_blocked: got %h expected %h", o_coeffs, exp_coeffs); end
        for (int i = 0; i < 600; i++) begin
            strobe(9'sd0, pre, post);
            if (pre !== 1'b0) pre_bad++;
            if (post === 1'b1) en_cnt++;
            if (i == 598) begin
                checks++;
                if (o_state !== 3'd2) begin errors++; $display("FAIL train_599: got %0d expected 2", o_state); end
            end
        end
        checks += 3;
        if (o_state !== 3'd3) begin errors++; $display("FAIL train_to_track: got %0d expected 3", o_state); end
        if (en_cnt !== 600) begin errors++; $display("FAIL train_enable_count: got %0d expected 600", en_cnt); end
        if (pre_bad !== 0) begin errors++; $display("FAIL train_enable_width: got %0d stale pulses expected 0", pre_bad); end
    endtask

    task automatic test_retrain;
        burst(63, -9'sd40);
        checks++;
        if (o_state !== 3'd3) begin errors++; $display("FAIL retrain_63: got %0d expected 3", o_state); end
        burst(1, -9'sd40);
        checks += 2;
        if (o_state !== 3'd2) begin errors++; $display("FAIL retrain_state: got %0d expected 2", o_state); end
        if (o_retrain_cnt !== 8'd1) begin errors++; $display("FAIL retrain_cnt1: got %0d expected 1", o_retrain_cnt); end
        to_track;
        checks++;
        if (o_state !== 3'd3) begin errors++; $display("FAIL freeze_mid_train_to_track: got %0d expected 3", o_state); end
        burst(64, 9'sd20);
        checks += 2;
        if (o_state !== 3'd3) begin errors++; $display("FAIL track_hold_state: got %0d expected 3", o_state); end
        if (o_retrain_cnt !== 8'd1) begin errors++; $display("FAIL track_hold_cnt: got %0d expected 1", o_retrain_cnt); end
        burst(64, -9'sd40);
        checks += 2;
        if (o_state !== 3'd2) begin errors++; $display("FAIL retrain2_state: got %0d expected 2", o_state); end
        if (o_retrain_cnt !== 8'd2) begin errors++; $display("FAIL retrain2_cnt: got %0d expected 2", o_retrain_cnt); end
        to_track;
    endtask

    task automatic test_freeze;
        logic pre, post;
        burst(63, -9'sd40);
        @(negedge clkA); i_sym_valid = 1'b1; i_e = -9'sd40; i_freeze = 1'b1;
        @(negedge clkA); i_sym_valid = 1'b0;
        checks += 2;
        if (o_enable !== 1'b0) begin errors++; $display("FAIL freeze_enable: got %b expected 0", o_enable); end
        if (o_state !== 3'd4) begin errors++; $display("FAIL freeze_state: got %0d expected 4", o_state); end
        strobe(9'sd7, pre, post);
        checks++;
        if (post !== 1'b0) begin errors++; $display("FAIL frozen_strobe_enable: got %b expected 0", post); end
        cfg_write(4'd0, 7'sd21, 1'b1);
        exp_coeffs[0 +: NBw] = 7'd21;
        checks++;
        if (o_coeffs !== exp_coeffs) begin errors++; $display("FAIL freeze_write: got %h expected %h", o_coeffs, exp_coeffs); end
        @(negedge clkA); cfg_commit = 1'b1;
        @(negedge clkA); cfg_commit = 1'b0;
        checks += 2;
        if (o_state !== 3'd1) begin errors++; $display("FAIL freeze_commit_state: got %0d expected 1", o_state); end
        if (o_debug_load !== 1'b1) begin errors++; $display("FAIL freeze_commit_load: got %b expected 1", o_debug_load); end
        @(negedge clkA);
        checks++;
        if (o_state !== 3'd4) begin errors++; $display("FAIL commit_return_freeze: got %0d expected 4", o_state); end
        @(negedge clkA); i_freeze = 1'b0;
        @(negedge clkA);
        checks++;
        if (o_state !== 3'd3) begin errors++; $display("FAIL unfreeze_state: got %0d expected 3", o_state); end
        burst(64, 9'sd20);
        checks += 2;
        if (o_state !== 3'd3) begin errors++; $display("FAIL unfreeze_acc_clear: got %0d expected 3", o_state); end
        if (o_retrain_cnt !== 8'd2) begin errors++; $display("FAIL freeze_no_retrain: got %0d expected 2", o_retrain_cnt); end
    endtask

    task automatic test_boundary;
        burst(64, 9'sd32);
        checks += 2;
        if (o_state !== 3'd3) begin errors++; $display("FAIL th_equal_state: got %0d expected 3", o_state); end
        if (o_retrain_cnt !== 8'd2) begin errors++; $display("FAIL th_equal_cnt: got %0d expected 2", o_retrain_cnt); end
        burst(64, 9'sd33);
        checks += 2;
        if (o_state !== 3'd2) begin errors++; $display("FAIL th_above_state: got %0d expected 2", o_state); end
        if (o_retrain_cnt !== 8'd3) begin errors++; $display("FAIL th_above_cnt: got %0d expected 3", o_retrain_cnt); end
        to_track;
        burst(64, -9'sd256);
        checks += 2;
        if (o_state !== 3'd2) begin errors++; $display("FAIL min_err_state: got %0d expected 2", o_state); end
        if (o_retrain_cnt !== 8'd4) begin errors++; $display("FAIL min_err_cnt: got %0d expected 4", o_retrain_cnt); end
        for (int i = 0; i < 296; i++) begin
            to_track;
            burst(64, -9'sd256);
        end
        checks += 2;
        if (o_retrain_cnt !== 8'd255) begin errors++; $display("FAIL retrain_saturate: got %0d expected 255", o_retrain_cnt); end
        if (o_state !== 3'd2) begin errors++; $display("FAIL saturate_state: got %0d expected 2", o_state); end
    endtask

    task automatic test_async_reset;
        to_track;
        @(negedge clkA); i_sym_valid = 1'b1; i_e = 9'sd1;
        @(negedge clkA);
        checks++;
        if (o_enable !== 1'b1) begin errors++; $display("FAIL pre_reset_enable: got %b expected 1", o_enable); end
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (o_enable !== 1'b0) begin errors++; $display("FAIL async_reset_enable: got %b expected 0", o_enable); end
        if (o_state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", o_state); end
        if (o_coeffs !== def_coeffs) begin errors++; $display("FAIL async_reset_coeffs: got %h expected %h", o_coeffs, def_coeffs); end
        if (o_retrain_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d expected 0", o_retrain_cnt); end
        i_sym_valid = 1'b0;
        @(negedge clkA); reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        def_coeffs = '0;
        def_coeffs[(Nw/2)*NBw +: NBw] = 7'd32;
        exp_coeffs = def_coeffs;
        test_reset;
        test_cfg_commit;
        test_train;
        test_retrain;
        test_freeze;
        test_boundary;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
